// File: rtl/exc_commit.sv
// Exception/ERET commit unit: prioritises WB exception flags, interrupt and ERET, drains the bus, then commits.
// Optional build macro EXC_IV_EN: interrupts with Cause.IV=1 use the 0x200 vector offset.
module exc_commit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic [11:0] wb_exc,
  input  logic        wb_refill,
  input  logic [31:0] wb_badvaddr,
  input  logic        wb_eret,
  input  logic        int_sig,
  input  logic        status_bev,
  input  logic        status_exl,
  input  logic        cause_iv,
  input  logic [31:0] epc,
  input  logic        mem_busy,
  output logic        commit_exc,
  output logic        commit_eret,
  output logic [4:0]  commit_code,
  output logic        commit_bd,
  output logic [31:0] commit_epc,
  output logic [31:0] commit_bvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, RECOVER} state_t;

  localparam logic [3:0] RECOVER_INIT = 4'(FLUSH_CYCLES - 1);

  // state_q is the FSM state visible to checkers
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        latch_en;

  logic [4:0]  code_q;
  logic        eret_q, bd_q;
  logic [31:0] epc_q, bvaddr_q, vec_q;

  logic        event_det;
  logic [4:0]  sel_code;
  logic        sel_eret, sel_fetch, sel_tlb, sel_int;
  logic [31:0] vec_base, vec_off;

  assign event_det = wb_valid && (int_sig || (|wb_exc) || wb_eret);

  // wb_exc bit order already matches exception priority, below the interrupt
  always_comb begin
    sel_code  = 5'd0;
    sel_eret  = 1'b0;
    sel_fetch = 1'b0;
    sel_tlb   = 1'b0;
    sel_int   = 1'b0;
    if (int_sig)         sel_int = 1'b1;
    else if (wb_exc[0])  begin sel_code = 5'd4;  sel_fetch = 1'b1; end
    else if (wb_exc[1])  begin sel_code = 5'd2;  sel_fetch = 1'b1; sel_tlb = 1'b1; end
    else if (wb_exc[2])  sel_code = 5'd10;
    else if (wb_exc[3])  sel_code = 5'd11;
    else if (wb_exc[4])  sel_code = 5'd8;
    else if (wb_exc[5])  sel_code = 5'd9;
    else if (wb_exc[6])  sel_code = 5'd12;
    else if (wb_exc[7])  sel_code = 5'd4;
    else if (wb_exc[8])  sel_code = 5'd5;
    else if (wb_exc[9])  begin sel_code = 5'd2; sel_tlb = 1'b1; end
    else if (wb_exc[10]) begin sel_code = 5'd3; sel_tlb = 1'b1; end
    else if (wb_exc[11]) sel_code = 5'd1;
    else                 sel_eret = wb_eret;
  end

  always_comb begin
    vec_base = status_bev ? 32'hBFC0_0200 : 32'h8000_0000;
    vec_off  = 32'h0000_0180;
    if (sel_tlb && wb_refill && !status_exl) vec_off = 32'h0000_0000;
`ifdef EXC_IV_EN
    if (sel_int && cause_iv) vec_off = 32'h0000_0200;
`endif
  end

`ifndef EXC_IV_EN
  logic unused_cause_iv;
  assign unused_cause_iv = cause_iv;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    latch_en       = 1'b0;
    wb_ready       = 1'b0;
    commit_exc     = 1'b0;
    commit_eret    = 1'b0;
    commit_code    = 5'd0;
    commit_bd      = 1'b0;
    commit_epc     = 32'd0;
    commit_bvaddr  = 32'd0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if (resetn) begin
      unique case (state_q)
        IDLE: begin
          wb_ready = !event_det;
          if (event_det) begin
            latch_en = 1'b1;
            state_d  = mem_busy ? DRAIN : COMMIT;
          end
        end
        DRAIN: begin
          if (!mem_busy) state_d = COMMIT;
        end
        COMMIT: begin
          commit_exc     = 1'b1;
          commit_eret    = eret_q;
          commit_code    = code_q;
          commit_bd      = bd_q;
          commit_epc     = epc_q;
          commit_bvaddr  = bvaddr_q;
          flush          = 1'b1;
          redirect_valid = 1'b1;
          // ERET returns to the EPC as CP0 holds it in this very cycle
          redirect_pc    = eret_q ? epc : vec_q;
          cnt_d          = RECOVER_INIT;
          state_d        = RECOVER;
        end
        RECOVER: begin
          flush = 1'b1;
          if (cnt_q == 4'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      code_q   <= 5'd0;
      eret_q   <= 1'b0;
      bd_q     <= 1'b0;
      epc_q    <= 32'd0;
      bvaddr_q <= 32'd0;
      vec_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        code_q   <= sel_code;
        eret_q   <= sel_eret;
        bd_q     <= wb_bd;
        epc_q    <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
        bvaddr_q <= sel_fetch ? wb_pc : wb_badvaddr;
        vec_q    <= vec_base + vec_off;
      end
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: priorities, vectors, drain, ERET, reset during drain.
module tb_exc_commit;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_ready, wb_bd, wb_refill, wb_eret;
  logic [31:0] wb_pc, wb_badvaddr, epc;
  logic [11:0] wb_exc;
  logic        int_sig, status_bev, status_exl, cause_iv, mem_busy;
  logic        commit_exc, commit_eret, commit_bd, flush, redirect_valid;
  logic [4:0]  commit_code;
  logic [31:0] commit_epc, commit_bvaddr, redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  exc_commit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_bd(wb_bd), .wb_exc(wb_exc), .wb_refill(wb_refill),
    .wb_badvaddr(wb_badvaddr), .wb_eret(wb_eret), .int_sig(int_sig),
    .status_bev(status_bev), .status_exl(status_exl), .cause_iv(cause_iv),
    .epc(epc), .mem_busy(mem_busy), .commit_exc(commit_exc),
    .commit_eret(commit_eret), .commit_code(commit_code), .commit_bd(commit_bd),
    .commit_epc(commit_epc), .commit_bvaddr(commit_bvaddr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present an instruction in WB; it must not retire this cycle
  task automatic fire(input string tag, input logic [31:0] pc, input logic [11:0] exc,
                      input logic eret, input logic bd);
    wb_pc    = pc;
    wb_exc   = exc;
    wb_eret  = eret;
    wb_bd    = bd;
    wb_valid = 1'b1;
    #1;
    check_eq({tag, "_det_ready"}, 32'(wb_ready), 32'd0);
  endtask

  task automatic expect_commit(input string tag, input logic [4:0] code, input logic eret,
                               input logic bd, input logic [31:0] e_epc,
                               input logic [31:0] bva, input logic [31:0] rpc);
    check_eq({tag, "_exc"},    32'(commit_exc), 32'd1);
    check_eq({tag, "_flush"},  32'(flush), 32'd1);
    check_eq({tag, "_rvalid"}, 32'(redirect_valid), 32'd1);
    check_eq({tag, "_ready"},  32'(wb_ready), 32'd0);
    check_eq({tag, "_code"},   32'(commit_code), 32'(code));
    check_eq({tag, "_eret"},   32'(commit_eret), 32'(eret));
    check_eq({tag, "_bd"},     32'(commit_bd), 32'(bd));
    check_eq({tag, "_epc"},    commit_epc, e_epc);
    check_eq({tag, "_bvaddr"}, commit_bvaddr, bva);
    check_eq({tag, "_rpc"},    redirect_pc, rpc);
    wb_valid = 1'b0;
    wb_exc   = 12'd0;
    wb_eret  = 1'b0;
    wb_bd    = 1'b0;
    int_sig  = 1'b0;
  endtask

  task automatic finish_recover(input string tag);
    for (int i = 0; i < FC; i++) begin
      step();
      check_eq({tag, "_rec_flush"}, 32'(flush), 32'd1);
      check_eq({tag, "_rec_ready"}, 32'(wb_ready), 32'd0);
      check_eq({tag, "_rec_exc"},   32'(commit_exc), 32'd0);
    end
    step();
    check_eq({tag, "_idle_flush"}, 32'(flush), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(wb_ready), 32'd1);
  endtask

  initial begin
    resetn = 1'b0; wb_valid = 1'b0; wb_bd = 1'b0; wb_refill = 1'b0; wb_eret = 1'b0;
    wb_pc = 32'd0; wb_badvaddr = 32'd0; epc = 32'd0; wb_exc = 12'd0;
    int_sig = 1'b0; status_bev = 1'b0; status_exl = 1'b0; cause_iv = 1'b0; mem_busy = 1'b0;

    step(); step();
    check_eq("rst_ready",  32'(wb_ready), 32'd0);
    check_eq("rst_flush",  32'(flush), 32'd0);
    check_eq("rst_exc",    32'(commit_exc), 32'd0);
    check_eq("rst_rvalid", 32'(redirect_valid), 32'd0);
    resetn = 1'b1;
    step();
    check_eq("post_rst_ready", 32'(wb_ready), 32'd1);

    // plain instruction retires, nothing committed
    wb_valid = 1'b1; #1;
    check_eq("plain_ready", 32'(wb_ready), 32'd1);
    step();
    check_eq("plain_exc", 32'(commit_exc), 32'd0);
    wb_valid = 1'b0;

    // Sys with BEV=1
    status_bev = 1'b1;
    fire("sys", 32'hBFC0_0010, 12'h010, 1'b0, 1'b0);
    step();
    expect_commit("sys", 5'd8, 1'b0, 1'b0, 32'hBFC0_0010, 32'h0, 32'hBFC0_0380);
    finish_recover("sys");
    status_bev = 1'b0;

    // data TLBL refill, EXL=0 then EXL=1
    wb_refill = 1'b1; wb_badvaddr = 32'h0040_1234;
    fire("refill", 32'h8000_0100, 12'h200, 1'b0, 1'b0);
    step();
    expect_commit("refill", 5'd2, 1'b0, 1'b0, 32'h8000_0100, 32'h0040_1234, 32'h8000_0000);
    finish_recover("refill");
    status_exl = 1'b1;
    fire("refill_exl", 32'h8000_0100, 12'h200, 1'b0, 1'b0);
    step();
    expect_commit("refill_exl", 5'd2, 1'b0, 1'b0, 32'h8000_0100, 32'h0040_1234, 32'h8000_0180);
    finish_recover("refill_exl");
    status_exl = 1'b0;
    wb_refill  = 1'b0;

    // Ov in a delay slot while the bus drains; late int_sig must not change the event
    mem_busy = 1'b1;
    fire("ov", 32'h8000_1004, 12'h040, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      wb_valid = 1'b0;
      int_sig  = 1'b1;
      check_eq("ov_drain_ready", 32'(wb_ready), 32'd0);
      check_eq("ov_drain_exc",   32'(commit_exc), 32'd0);
      check_eq("ov_drain_flush", 32'(flush), 32'd0);
    end
    mem_busy = 1'b0;
    step();
    expect_commit("ov", 5'd12, 1'b0, 1'b1, 32'h8000_1000, 32'h0040_1234, 32'h8000_0180);
    finish_recover("ov");

    // interrupt beats RI; IV offset only in the optional build
    cause_iv = 1'b1; int_sig = 1'b1;
    fire("int", 32'h8000_0200, 12'h004, 1'b0, 1'b0);
    step();
`ifdef EXC_IV_EN
    expect_commit("int", 5'd0, 1'b0, 1'b0, 32'h8000_0200, 32'h0040_1234, 32'h8000_0200);
`else
    expect_commit("int", 5'd0, 1'b0, 1'b0, 32'h8000_0200, 32'h0040_1234, 32'h8000_0180);
`endif
    finish_recover("int");
    cause_iv = 1'b0;

    // ERET: target is EPC as seen in the commit cycle
    epc = 32'h1111_1110;
    fire("eret", 32'h8000_0300, 12'h000, 1'b1, 1'b0);
    step();
    epc = 32'h8000_2000; #1;
    expect_commit("eret", 5'd0, 1'b1, 1'b0, 32'h8000_0300, 32'h0040_1234, 32'h8000_2000);
    finish_recover("eret");

    // ERET with CpU: exception wins
    fire("cpu", 32'h8000_0400, 12'h008, 1'b1, 1'b0);
    step();
    expect_commit("cpu", 5'd11, 1'b0, 1'b0, 32'h8000_0400, 32'h0040_1234, 32'h8000_0180);
    finish_recover("cpu");

    // fetch AdEL: BadVAddr comes from the PC
    fire("fadel", 32'h8000_0AB2, 12'h081, 1'b0, 1'b0);
    step();
    expect_commit("fadel", 5'd4, 1'b0, 1'b0, 32'h8000_0AB2, 32'h8000_0AB2, 32'h8000_0180);
    finish_recover("fadel");

    // fetch TLBL refill goes to the refill vector
    wb_refill = 1'b1;
    fire("ftlb", 32'h0040_0000, 12'h002, 1'b0, 1'b0);
    step();
    expect_commit("ftlb", 5'd2, 1'b0, 1'b0, 32'h0040_0000, 32'h0040_0000, 32'h8000_0000);
    finish_recover("ftlb");
    wb_refill = 1'b0;

    // AdES beats Mod; delay-slot EPC wraps below zero
    fire("ades", 32'h0000_0000, 12'h900, 1'b0, 1'b1);
    step();
    expect_commit("ades", 5'd5, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0040_1234, 32'h8000_0180);
    finish_recover("ades");

    // reset in the middle of DRAIN cancels the commit
    mem_busy = 1'b1;
    fire("rstd", 32'h8000_0500, 12'h010, 1'b0, 1'b0);
    step();
    wb_valid = 1'b0; wb_exc = 12'd0;
    resetn = 1'b0;
    step();
    check_eq("rstd_ready",  32'(wb_ready), 32'd0);
    check_eq("rstd_flush",  32'(flush), 32'd0);
    check_eq("rstd_exc",    32'(commit_exc), 32'd0);
    check_eq("rstd_rvalid", 32'(redirect_valid), 32'd0);
    check_eq("rstd_rpc",    redirect_pc, 32'd0);
    check_eq("rstd_code",   32'(commit_code), 32'd0);
    check_eq("rstd_epc",    commit_epc, 32'd0);
    resetn = 1'b1; mem_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rstd_after_exc",   32'(commit_exc), 32'd0);
      check_eq("rstd_after_flush", 32'(flush), 32'd0);
    end
    check_eq("rstd_after_ready", 32'(wb_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
